// File: rtl/fifo_reader.sv
// fifo_reader: drains a commanded burst of bytes from the team FIFO into a 3-entry skid
// buffer and presents them on a valid/ready stream. Define FIFO_READER_CHECKSUM_EN for the XOR checksum.
module fifo_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        count,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        remaining;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [0:2];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        buf_count;
    logic [2:0]        credit_used;
    logic              capture;
    logic              pop;
    logic              start_ok;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when the buffer is guaranteed room for it once it lands.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight};
    assign fifo_r_en   = (state == S_RUN) && (remaining != 8'd0) && !fifo_empty
                         && (credit_used < 3'd3);

    assign capture  = inflight;
    assign m_valid  = (buf_count != 2'd0);
    assign m_data   = buf_mem[rd_ptr];
    assign pop      = m_valid && m_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign start_ok = (state == S_IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (burst_len == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (fifo_r_en && (remaining == 8'd1)) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leave as soon as the final byte is being handed off, so done follows it directly.
                if (!inflight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= 8'd0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_r_en;
            if (start_ok) begin
                remaining <= burst_len;
            end else if (fifo_r_en) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            buf_count <= 2'd0;
        end else begin
            if (capture) begin
                buf_mem[wr_ptr] <= fifo_data;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({capture, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (start_ok) begin
            count <= 8'd0;
        end else if (pop) begin
            count <= count + 8'd1;
        end
    end

`ifdef FIFO_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q ^ m_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: drives fifo_reader from a queue-based FIFO model and checks delivered
// bytes, counts, checksum and timing against a burst-level reference model.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] count;
    logic [7:0] checksum;

    int errors = 0;
    int checks = 0;

    fifo_reader #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO with registered data_out
    logic       push_en = 1'b0;
    logic [7:0] push_byte = 8'd0;
    logic [7:0] fifo_q[$];

    always @(posedge clk) begin
        if (push_en) fifo_q.push_back(push_byte);
        if (fifo_r_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Reference model state: bytes the FIFO holds, in order, not yet consumed
    logic [7:0] ref_q[$];
    logic [7:0] stage_q[$];
    logic [7:0] exp_q[$];
    bit         rand_ready = 0;

    // Monitor, sampling mid-cycle
    int         cyc = 0;
    int         rd_cnt, hs_cnt, done_cnt, viol_cnt, ovf_cnt;
    int         start_cyc, done_cyc, first_valid_cyc, first_rd_cyc;
    logic [7:0] got_q[$];
    int         hs_cyc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (start && !busy) start_cyc = cyc;
            if (fifo_r_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (fifo_empty) viol_cnt++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                hs_cyc_q.push_back(cyc);
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_cnt - hs_cnt > 3) ovf_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] exp_checksum(input logic [7:0] q[$]);
        logic [7:0] x = 8'd0;
`ifdef FIFO_READER_CHECKSUM_EN
        foreach (q[i]) x = x ^ q[i];
`endif
        return x;
    endfunction

    task automatic clear_mon();
        rd_cnt = 0; hs_cnt = 0; done_cnt = 0; viol_cnt = 0; ovf_cnt = 0;
        start_cyc = -1; done_cyc = -1; first_valid_cyc = -1; first_rd_cyc = -1;
        got_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic load_fifo();
        foreach (stage_q[i]) begin
            @(negedge clk);
            push_en   = 1'b1;
            push_byte = stage_q[i];
            ref_q.push_back(stage_q[i]);
        end
        @(negedge clk);
        push_en = 1'b0;
        stage_q.delete();
    endtask

    task automatic take_expected(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(ref_q.pop_front());
    endtask

    task automatic pulse_start(input logic [7:0] len);
        @(negedge clk);
        start     = 1'b1;
        burst_len = len;
        @(negedge clk);
        start     = 1'b0;
        burst_len = 8'($urandom);
    endtask

    task automatic wait_done(input int bound, output bit seen);
        int n0 = done_cnt;
        seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rand_ready) m_ready = (($urandom & 1) != 0);
            if (done_cnt > n0) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_en: got %b expected 0", fifo_r_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_data: got %0d expected 0", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (checksum !== 8'd0) begin errors++; $display("[TB] FAIL reset_checksum: got %0d expected 0", checksum); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit seen;
        logic [7:0] cs;
        stage_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        load_fifo();
        take_expected(4);
        m_ready = 1'b1;
        clear_mon();
        pulse_start(8'd4);
        wait_done(60, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL basic_done: got no done expected done pulse"); end
        checks++; if (got_q.size() != 4) begin errors++; $display("[TB] FAIL basic_len: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        if (hs_cyc_q.size() == 4) begin
            checks++;
            if (hs_cyc_q[3] - hs_cyc_q[0] != 3) begin errors++; $display("[TB] FAIL basic_throughput: got span %0d expected 3", hs_cyc_q[3] - hs_cyc_q[0]); end
            checks++;
            if (done_cyc != hs_cyc_q[3] + 1) begin errors++; $display("[TB] FAIL basic_done_time: got %0d expected %0d", done_cyc, hs_cyc_q[3] + 1); end
        end
        checks++; if (first_rd_cyc != start_cyc + 1) begin errors++; $display("[TB] FAIL basic_first_read: got %0d expected %0d", first_rd_cyc, start_cyc + 1); end
        checks++; if (first_valid_cyc != start_cyc + 3) begin errors++; $display("[TB] FAIL basic_first_valid: got %0d expected %0d", first_valid_cyc, start_cyc + 3); end
        checks++; if (count !== 8'd4) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 4", count); end
        cs = exp_checksum(exp_q);
        checks++; if (checksum !== cs) begin errors++; $display("[TB] FAIL basic_checksum: got %0h expected %0h", checksum, cs); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_width: got %0d expected 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit seen;
        for (int i = 0; i < 6; i++) stage_q.push_back(8'($urandom));
        load_fifo();
        take_expected(6);
        m_ready = 1'b0;
        clear_mon();
        pulse_start(8'd6);
        repeat (10) @(negedge clk);
        checks++; if (rd_cnt != 3) begin errors++; $display("[TB] FAIL bp_reads: got %0d expected 3", rd_cnt); end
        checks++; if (hs_cnt != 0) begin errors++; $display("[TB] FAIL bp_no_hs: got %0d expected 0", hs_cnt); end
        m_ready = 1'b1;
        wait_done(60, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL bp_done: got no done expected done pulse"); end
        checks++; if (got_q.size() != 6) begin errors++; $display("[TB] FAIL bp_len: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        checks++; if (count !== 8'd6) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 6", count); end
        checks++; if (ovf_cnt != 0) begin errors++; $display("[TB] FAIL bp_overflow: got %0d expected 0", ovf_cnt); end
    endtask

    task automatic test_zero_len();
        bit seen;
        m_ready = 1'b1;
        clear_mon();
        pulse_start(8'd0);
        wait_done(10, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL zero_done: got no done expected done pulse"); end
        checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("[TB] FAIL zero_done_time: got %0d expected %0d", done_cyc, start_cyc + 1); end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL zero_count: got %0d expected 0", count); end
        checks++; if (checksum !== 8'd0) begin errors++; $display("[TB] FAIL zero_checksum: got %0h expected 0", checksum); end
        repeat (3) @(negedge clk);
        checks++; if (rd_cnt != 0) begin errors++; $display("[TB] FAIL zero_reads: got %0d expected 0", rd_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL zero_done_width: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_empty_stall();
        bit seen;
        for (int i = 0; i < 2; i++) stage_q.push_back(8'($urandom));
        load_fifo();
        m_ready = 1'b1;
        clear_mon();
        pulse_start(8'd4);
        repeat (8) @(negedge clk);
        checks++; if (hs_cnt != 2) begin errors++; $display("[TB] FAIL stall_hs: got %0d expected 2", hs_cnt); end
        checks++; if (busy !== 1'b1 || done_cnt != 0) begin errors++; $display("[TB] FAIL stall_busy: got busy=%b done_cnt=%0d expected busy=1 done_cnt=0", busy, done_cnt); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) stage_q.push_back(8'($urandom));
        load_fifo();
        take_expected(4);
        wait_done(40, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL stall_done: got no done expected done pulse"); end
        checks++; if (got_q.size() != 4) begin errors++; $display("[TB] FAIL stall_len: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        if (hs_cyc_q.size() == 4) begin
            checks++;
            if (done_cyc <= hs_cyc_q[3]) begin errors++; $display("[TB] FAIL stall_done_order: got done at %0d expected after %0d", done_cyc, hs_cyc_q[3]); end
        end
        checks++; if (viol_cnt != 0) begin errors++; $display("[TB] FAIL stall_read_empty: got %0d expected 0", viol_cnt); end
        checks++; if (count !== 8'd4) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 4", count); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit reached = 0;
        for (int i = 0; i < 6; i++) stage_q.push_back(8'($urandom));
        load_fifo();
        m_ready = 1'b1;
        clear_mon();
        pulse_start(8'd6);
        for (int i = 0; i < 40; i++) begin
            if (hs_cnt >= 2) begin reached = 1; break; end
            @(negedge clk);
        end
        checks++; if (!reached) begin errors++; $display("[TB] FAIL rmid_reach: got %0d handshakes expected 2", hs_cnt); end
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", m_valid); end
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_r_en: got %b expected 0", fifo_r_en); end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d expected 0", count); end
        checks++; if (m_data !== 8'd0) begin errors++; $display("[TB] FAIL rmid_m_data: got %0d expected 0", m_data); end
        // every byte read before the reset is gone from the FIFO
        for (int i = 0; i < rd_cnt; i++) void'(ref_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        take_expected(2);
        clear_mon();
        pulse_start(8'd2);
        wait_done(40, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rmid_done: got no done expected done pulse"); end
        checks++; if (got_q.size() != 2) begin errors++; $display("[TB] FAIL rmid_len: got %0d expected 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rmid_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        checks++; if (count !== 8'd2) begin errors++; $display("[TB] FAIL rmid_count2: got %0d expected 2", count); end
    endtask

    task automatic test_start_while_busy();
        bit seen;
        for (int i = 0; i < 5; i++) stage_q.push_back(8'($urandom));
        load_fifo();
        take_expected(3);
        m_ready = 1'b0;
        clear_mon();
        pulse_start(8'd3);
        repeat (2) @(negedge clk);
        pulse_start(8'd5);
        m_ready = 1'b1;
        wait_done(40, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL busy_done: got no done expected done pulse"); end
        checks++; if (count !== 8'd3) begin errors++; $display("[TB] FAIL busy_count: got %0d expected 3", count); end
        checks++; if (got_q.size() != 3) begin errors++; $display("[TB] FAIL busy_len: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL busy_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        repeat (5) @(negedge clk);
        checks++; if (rd_cnt != 3) begin errors++; $display("[TB] FAIL busy_reads: got %0d expected 3", rd_cnt); end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_single_burst: got done_cnt=%0d busy=%b expected 1 and 0", done_cnt, busy); end
    endtask

    task automatic test_random();
        bit seen;
        int len;
        logic [7:0] cs;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) stage_q.push_back(8'($urandom));
            load_fifo();
            take_expected(len);
            clear_mon();
            rand_ready = 1;
            pulse_start(8'(len));
            wait_done(400, seen);
            rand_ready = 0;
            m_ready = 1'b1;
            checks++; if (!seen) begin errors++; $display("[TB] FAIL rand%0d_done: got no done expected done pulse", it); end
            checks++; if (got_q.size() != len) begin errors++; $display("[TB] FAIL rand%0d_len: got %0d expected %0d", it, got_q.size(), len); end
            for (int i = 0; i < len && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand%0d_data[%0d]: got %0d expected %0d", it, i, got_q[i], exp_q[i]); end
            end
            checks++; if (count !== 8'(len)) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, count, len); end
            cs = exp_checksum(exp_q);
            checks++; if (checksum !== cs) begin errors++; $display("[TB] FAIL rand%0d_checksum: got %0h expected %0h", it, checksum, cs); end
            checks++; if (ovf_cnt != 0 || viol_cnt != 0) begin errors++; $display("[TB] FAIL rand%0d_credit: got ovf=%0d viol=%0d expected 0 and 0", it, ovf_cnt, viol_cnt); end
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_empty_stall();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's 8-bit synchronous FIFO. It drains a commanded number of bytes from the FIFO through the FIFO's `r_en`/`empty`/`data_out` port. It presents those bytes downstream on a valid/ready stream through a 3-entry skid buffer, then pulses `done`. It sits between the FIFO and any consumer that needs burst-framed, back-pressurable delivery.

## Interface
- `DATA_W`, default 8: byte width, matching the FIFO data width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that starts a burst; sampled only in IDLE.
- `burst_len`, input, 8: number of bytes to transfer, sampled with `start`.
- `fifo_empty`, input, 1: the FIFO's `empty` flag.
- `fifo_data`, input, DATA_W: the FIFO's registered `data_out`.
- `fifo_r_en`, output, 1: read strobe to the FIFO.
- `m_valid`, output, 1: downstream byte valid.
- `m_data`, output, DATA_W: downstream byte.
- `m_ready`, input, 1: downstream accept.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of a burst.
- `count`, output, 8: bytes accepted downstream in the current or last burst.
- `checksum`, output, DATA_W: XOR of bytes delivered (see Configuration).

## Operation
- States are IDLE, RUN, FLUSH and DONE.
- **IDLE**
  - On `start` with `burst_len` ≠ 0: latch `remaining = burst_len`, clear `count` and `checksum`, go to RUN.
  - On `start` with `burst_len` = 0: go directly to DONE.
- **RUN**
  - `fifo_r_en` is combinational: `state==RUN && remaining!=0 && !fifo_empty && (buf_count + inflight) < 3`.
  - `inflight` is a register set to the value of `fifo_r_en` from the previous cycle.
  - Each `fifo_r_en` decrements `remaining`.
  - When `remaining` reaches 0, go to FLUSH.
- **FLUSH**
  - No reads are issued.
  - Go to DONE once `inflight==0`, `buf_count==0`, and the final handshake has completed.
- **DONE**
  - `done` is high for exactly one cycle, then the state returns to IDLE.
- **Capture:** in any cycle with `inflight==1`, `fifo_data` is written to the buffer tail.
- **Skid buffer:** 3-entry circular buffer with wrapping 2-bit pointers and `buf_count` 0..3.
  - `m_valid = (buf_count != 0)`; `m_data` is the head entry.
  - A handshake (`m_valid && m_ready`) pops the head, increments `count`, and XORs the byte into `checksum`.
  - A simultaneous capture and pop leaves `buf_count` unchanged.
- **Boundary conditions**
  - The credit rule guarantees the buffer never overflows. Capture into a full buffer is impossible by construction; verification asserts it.
  - `fifo_r_en` is never high while `fifo_empty` is high.
  - An empty FIFO mid-burst stalls RUN indefinitely; there is no timeout.
  - `start` is ignored while `busy` is high.
  - `count` wraps modulo 256; it cannot exceed `burst_len`.
- **Reset:** asynchronous assertion forces the following, all 0: state IDLE, `fifo_r_en`, `m_valid`, `m_data`, `busy`, `done`, `count`, `checksum`, buffer pointers, `buf_count`, `inflight`, `remaining`. A byte in flight at reset is lost.

## Timing
- Read latency: `fifo_r_en` in cycle t, `fifo_data` valid in t+1, captured at the end of t+1, `m_valid` high in t+2.
- From `start` (cycle s) the earliest `fifo_r_en` is s+1, and the first `m_valid` is s+3.
- With `m_ready` held high and the FIFO non-empty, throughput is 1 byte per cycle.
- Backpressure: with `m_ready` low, at most 3 reads are issued, after which `fifo_r_en` stays low.
- `done` asserts the cycle after the state enters FLUSH-complete, i.e. the cycle after the last handshake at the earliest.
- `done` is high in cycle s+1 for `burst_len` = 0.
- `count` and `checksum` are stable and valid while `done` is high, and they hold until the next accepted `start`.

## Configuration
- Macro `FIFO_READER_CHECKSUM_EN`.
- Defined: `checksum` is the running XOR of bytes delivered in the current burst, cleared on accepted `start`.
- Undefined: the checksum logic is absent and `checksum` is tied to 0. All other behaviour is identical.

## Test plan
- Preload the FIFO with 10, 20, 30, 40; `burst_len`=4; `m_ready`=1.
  - Required: `m_data` 10, 20, 30, 40 on 4 consecutive cycles.
  - `done` pulse, `count`=4, `checksum`=0x28 (0 when the macro is undefined).
- Preload 6 bytes; `burst_len`=6; `m_ready`=0 for 10 cycles, then 1.
  - Required: exactly 3 `fifo_r_en` pulses during the stall.
  - All 6 bytes are then delivered in order; `count`=6.
- `burst_len`=0:
  - Required: `done` in the cycle after `start`.
  - `fifo_r_en` is never asserted; `count`=0.
- FIFO empty after 2 of 4 bytes; refill with 2 more 5 cycles later.
  - Required: stall with `fifo_r_en`=0 while empty; resume.
  - `done` only after byte 4; `fifo_r_en` never high while `fifo_empty` is high.
- Assert `rst` mid-burst after 2 handshakes:
  - Required: outputs immediately 0, state IDLE.
  - A following burst of 2 delivers the FIFO's next bytes in order.
- A second `start` while busy:
  - Required: ignored; the first burst completes with the original `count`.
